// File: rtl/mv_mesh_seq_if.sv
// Operand/result stream bundle for mv_mesh_seq: start/len control, operand beats,
// serial result drain and status.
interface mv_mesh_seq_if #(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned IDX_WIDTH  = 3,
  parameter int unsigned LEN_WIDTH  = 10,
  parameter int unsigned NUM_NODES  = 2 ** IDX_WIDTH
);
  logic                            start;
  logic [LEN_WIDTH-1:0]            len;
  logic                            in_valid;
  logic                            in_ready;
  logic [DATA_WIDTH-1:0]           in_vec;
  logic [DATA_WIDTH*NUM_NODES-1:0] in_mat;
  logic                            res_valid;
  logic                            res_ready;
  logic [DATA_WIDTH-1:0]           res_data;
  logic [IDX_WIDTH-1:0]            res_idx;
  logic                            busy;
  logic                            done;

  modport master (
    output start, len, in_valid, in_vec, in_mat, res_ready,
    input  in_ready, res_valid, res_data, res_idx, busy, done
  );

  modport slave (
    input  start, len, in_valid, in_vec, in_mat, res_ready,
    output in_ready, res_valid, res_data, res_idx, busy, done
  );
endinterface

// File: rtl/mv_mesh_seq.sv
// Self-sequencing matrix-vector systolic mesh, y = M*x, results drained serially.
// Optional MV_MESH_SAT_EN: clamp shifted result to DATA_WIDTH instead of wrapping.
module mv_mesh_seq #(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned IDX_WIDTH  = 3,
  parameter int unsigned NUM_NODES  = 2 ** IDX_WIDTH,
  parameter int unsigned LEN_WIDTH  = 10,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + LEN_WIDTH
) (
  input logic           clk,
  input logic           rst,
  mv_mesh_seq_if.slave  bus
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDrain} state_e;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0] row_q, row_d;
  logic                 done_q, done_d;

  logic                         accept, beat, adv;
  logic signed [DATA_WIDTH-1:0] x_q   [NUM_NODES];
  logic [NUM_NODES-1:0]         tag_q;
  logic signed [ACC_WIDTH-1:0]  acc_q [NUM_NODES];
  logic signed [DATA_WIDTH-1:0] a_w   [NUM_NODES];
  logic signed [PW-1:0]         prod_w[NUM_NODES];
  logic [DATA_WIDTH-1:0]        res_w;

  assign accept = (state_q == StIdle) && bus.start;
  assign beat   = (state_q == StLoad) && bus.in_valid;
  assign adv    = beat || (state_q == StFlush);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          len_d   = bus.len;
          cnt_d   = '0;
          row_d   = '0;
          state_d = (bus.len == '0) ? StDrain : StLoad;
        end
      end
      StLoad: begin
        if (bus.in_valid) begin
          if (cnt_q == len_q - LEN_WIDTH'(1)) begin
            cnt_d   = '0;
            state_d = StFlush;
          end else begin
            cnt_d = cnt_q + LEN_WIDTH'(1);
          end
        end
      end
      StFlush: begin
        if (cnt_q == LEN_WIDTH'(NUM_NODES - 1)) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + LEN_WIDTH'(1);
        end
      end
      StDrain: begin
        if (bus.res_ready) begin
          row_d = row_q + IDX_WIDTH'(1);
          if (row_q == IDX_WIDTH'(NUM_NODES - 1)) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs, all decoded from registers only
  always_comb begin
    bus.in_ready  = (state_q == StLoad);
    bus.res_valid = (state_q == StDrain);
    bus.busy      = (state_q != StIdle);
    bus.done      = done_q;
    bus.res_idx   = row_q;
    bus.res_data  = res_w;
  end

  // Skew lane for row i is i+1 deep so M[i][k] lands beside x[k] at node i.
  for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_row
    logic signed [DATA_WIDTH-1:0] lane_q [gi+1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j <= gi; j++) lane_q[j] <= '0;
      end else if (accept) begin
        for (int j = 0; j <= gi; j++) lane_q[j] <= '0;
      end else if (adv) begin
        lane_q[0] <= beat ? bus.in_mat[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int j = 1; j <= gi; j++) lane_q[j] <= lane_q[j-1];
      end
    end

    assign a_w[gi] = lane_q[gi];
  end

  always_comb begin
    for (int i = 0; i < int'(NUM_NODES); i++) begin
      prod_w[i] = PW'(a_w[i]) * PW'(x_q[i]);
    end
  end

  // Operand chain and accumulators; a node consumes its current pair on each advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
      for (int i = 0; i < int'(NUM_NODES); i++) begin
        x_q[i]   <= '0;
        acc_q[i] <= '0;
      end
    end else if (accept) begin
      tag_q <= '0;
      for (int i = 0; i < int'(NUM_NODES); i++) begin
        x_q[i]   <= '0;
        acc_q[i] <= '0;
      end
    end else if (adv) begin
      x_q[0]   <= beat ? bus.in_vec : '0;
      tag_q[0] <= beat;
      for (int i = 1; i < int'(NUM_NODES); i++) begin
        x_q[i]   <= x_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
      for (int i = 0; i < int'(NUM_NODES); i++) begin
        if (tag_q[i]) acc_q[i] <= acc_q[i] + ACC_WIDTH'(prod_w[i]);
      end
    end
  end

`ifdef MV_MESH_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SatMax =
    {{(ACC_WIDTH - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SatMin =
    {{(ACC_WIDTH - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  logic signed [ACC_WIDTH-1:0] sh_w;

  always_comb begin
    sh_w = acc_q[row_q] >>> FRAC_BITS;
    if (sh_w > SatMax)      res_w = SatMax[DATA_WIDTH-1:0];
    else if (sh_w < SatMin) res_w = SatMin[DATA_WIDTH-1:0];
    else                    res_w = sh_w[DATA_WIDTH-1:0];
  end
`else
  // Low DATA_WIDTH bits of the floor shift, i.e. two's-complement wrap.
  always_comb begin
    res_w = acc_q[row_q][FRAC_BITS +: DATA_WIDTH];
  end
`endif

endmodule

// File: tb/tb_mv_mesh_seq.sv
// Scoreboard bench for mv_mesh_seq: DATA_WIDTH=16, IDX_WIDTH=2, FRAC_BITS=8.
module tb_mv_mesh_seq;
  localparam int DW = 16;
  localparam int IW = 2;
  localparam int NN = 4;
  localparam int LW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mv_mesh_seq_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW), .LEN_WIDTH(LW)) bus ();

  mv_mesh_seq #(
    .DATA_WIDTH(DW), .IDX_WIDTH(IW), .LEN_WIDTH(LW), .FRAC_BITS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mat[NN][8];
  logic [DW-1:0] vec[8];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            edges    = 0;

  always @(posedge clk) edges++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required $finish");
    $fatal(1);
  end

  function automatic logic [DW-1:0] model(int row, int ln);
    longint acc, sh;
    acc = 0;
    for (int k = 0; k < ln; k++)
      acc += longint'($signed(mat[row][k])) * longint'($signed(vec[k]));
    sh = acc >>> 8;
`ifdef MV_MESH_SAT_EN
    if (sh > 32767) sh = 32767;
    else if (sh < -32768) sh = -32768;
`endif
    return sh[DW-1:0];
  endfunction

  task automatic set_identity();
    for (int i = 0; i < NN; i++)
      for (int k = 0; k < 8; k++) mat[i][k] = (i == k) ? 16'h0100 : 16'h0000;
    for (int k = 0; k < 8; k++) vec[k] = 16'((k + 1) * 256);
  endtask

  // Drives one pass; results are checked against the scoreboard as they drain.
  task automatic run_pass(input int ln, input bit stall, input int bp_row, input int bp_cyc,
                          input int inj_cyc, output int first_valid, output int done_cyc,
                          output int n_done);
    int   cyc, beats, lcyc, bp_left, post, t0;
    exp_t e;
    for (int i = 0; i < NN; i++) begin
      e.idx  = i;
      e.data = model(i, ln);
      sb.push_back(e);
    end
    first_valid = -1; done_cyc = -1; n_done = 0;
    beats = 0; lcyc = 0; bp_left = bp_cyc; post = -1;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.len = LW'(ln); bus.in_valid = 1'b0; bus.res_ready = 1'b1;
    t0 = edges;
    for (int it = 0; it < 300; it++) begin
      @(posedge clk); #1;
      cyc       = edges - t0;
      bus.start = (cyc == inj_cyc);
      bus.len   = (cyc == inj_cyc) ? LW'(2) : LW'(ln);
      if (cyc == 1) begin
        n_checks++;
        if (bus.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_in_pass: got %b, required 1", bus.busy);
        end
      end
      bus.in_valid = 1'b0;
      if (bus.in_ready && beats < ln) begin
        if (!stall || (lcyc % 2) == 0) begin
          bus.in_valid = 1'b1;
          bus.in_vec   = vec[beats];
          for (int i = 0; i < NN; i++) bus.in_mat[i*DW +: DW] = mat[i][beats];
          beats++;
        end
        lcyc++;
      end
      if (bus.done) begin
        n_done++;
        done_cyc = cyc;
        if (post < 0) post = 2;
      end
      bus.res_ready = 1'b1;
      if (bus.res_valid) begin
        if (first_valid < 0) first_valid = cyc;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL extra_result: got idx %0d data %h, required no result",
                   bus.res_idx, bus.res_data);
        end else if (bp_left > 0 && bus.res_idx == IW'(bp_row)) begin
          bus.res_ready = 1'b0;
          bp_left--;
          if (bus.res_idx !== IW'(sb[0].idx) || bus.res_data !== sb[0].data) begin
            n_fail++;
            $display("FAIL hold: got idx %0d data %h, required idx %0d data %h",
                     bus.res_idx, bus.res_data, sb[0].idx, sb[0].data);
          end
        end else begin
          e = sb.pop_front();
          if (bus.res_idx !== IW'(e.idx) || bus.res_data !== e.data) begin
            n_fail++;
            $display("FAIL result: got idx %0d data %h, required idx %0d data %h",
                     bus.res_idx, bus.res_data, e.idx, e.data);
          end
        end
      end
      if (post == 0) break;
      if (post > 0) post--;
    end
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.res_ready = 1'b1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL lost_results: got %0d undrained, required 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.in_ready, bus.res_valid, bus.busy, bus.done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got rdy/vld/busy/done %b%b%b%b, required 0000",
               bus.in_ready, bus.res_valid, bus.busy, bus.done);
    end
    n_checks++;
    if (bus.res_data !== '0 || bus.res_idx !== '0) begin
      n_fail++;
      $display("FAIL reset_result: got data %h idx %0d, required 0 0", bus.res_data, bus.res_idx);
    end
    rst = 1'b0;
  endtask

  task automatic check_timing(input string name, input int got_first, input int exp_first,
                              input int got_done, input int exp_done, input int got_n);
    n_checks++;
    if (exp_first >= 0 && got_first != exp_first) begin
      n_fail++;
      $display("FAIL %s_first_valid: got cycle %0d, required %0d", name, got_first, exp_first);
    end
    n_checks++;
    if (got_done != exp_done) begin
      n_fail++;
      $display("FAIL %s_done_cycle: got cycle %0d, required %0d", name, got_done, exp_done);
    end
    n_checks++;
    if (got_n != 1) begin
      n_fail++;
      $display("FAIL %s_done_count: got %0d pulses, required 1", name, got_n);
    end
  endtask

  task automatic test_identity();
    int f, d, n;
    set_identity();
    run_pass(4, 1'b0, -1, 0, -1, f, d, n);
    check_timing("identity", f, 9, d, 13, n);
  endtask

  task automatic test_overflow();
    int f, d, n;
    for (int i = 0; i < NN; i++)
      for (int k = 0; k < 8; k++) mat[i][k] = 16'h7FFF;
    for (int k = 0; k < 8; k++) vec[k] = 16'h7FFF;
    run_pass(4, 1'b0, -1, 0, -1, f, d, n);
    check_timing("overflow", f, 9, d, 13, n);
  endtask

  task automatic test_random();
    int f, d, n;
    for (int i = 0; i < NN; i++)
      for (int k = 0; k < 8; k++) mat[i][k] = 16'($urandom_range(0, 4000)) - 16'd2000;
    for (int k = 0; k < 8; k++) vec[k] = 16'($urandom_range(0, 4000)) - 16'd2000;
    run_pass(6, 1'b0, -1, 0, -1, f, d, n);
    check_timing("random", f, 11, d, 15, n);
  endtask

  task automatic test_stall();
    int f, d, n;
    set_identity();
    run_pass(4, 1'b1, -1, 0, -1, f, d, n);
    check_timing("stall", f, 12, d, 16, n);
  endtask

  task automatic test_backpressure();
    int f, d, n;
    set_identity();
    run_pass(4, 1'b0, 1, 5, -1, f, d, n);
    check_timing("backpressure", f, 9, d, 18, n);
  endtask

  task automatic test_len_zero();
    int f, d, n;
    set_identity();
    run_pass(0, 1'b0, -1, 0, -1, f, d, n);
    check_timing("len_zero", f, 1, d, 5, n);
  endtask

  task automatic test_start_in_load();
    int f, d, n;
    set_identity();
    run_pass(4, 1'b0, -1, 0, 2, f, d, n);
    check_timing("start_in_load", f, 9, d, 13, n);
  endtask

  task automatic test_reset_mid();
    int f, d, n;
    for (int i = 0; i < NN; i++)
      for (int k = 0; k < 8; k++) mat[i][k] = 16'h0300;
    for (int k = 0; k < 8; k++) vec[k] = 16'h0200;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.len = LW'(4);
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_vec   = vec[0];
    for (int i = 0; i < NN; i++) bus.in_mat[i*DW +: DW] = mat[i][0];
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: got busy %b in_ready %b, required 0 0",
               bus.busy, bus.in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    set_identity();
    run_pass(4, 1'b0, -1, 0, -1, f, d, n);
    check_timing("reset_mid", f, 9, d, 13, n);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.in_mat    = '0;
    bus.res_ready = 1'b1;
    test_reset();
    test_identity();
    test_overflow();
    test_random();
    test_stall();
    test_backpressure();
    test_len_zero();
    test_start_in_load();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mv_mesh_seq.md
# mv_mesh_seq

Parametrised, self-sequencing matrix-vector systolic mesh computing y = M·x for NUM_NODES rows over a runtime vector length. It supersedes the externally-steered mesh: internal skew lanes, valid-tagged operand chain, and an FSM replace the external select lines. Results are drained serially over a valid/ready stream. It sits between the matrix/vector BRAM readers and the result write-back path of the MV accelerator.

## Interface
- DATA_WIDTH, 18: signed operand and result width.
- IDX_WIDTH, 3: log2 of node count.
- NUM_NODES, 2**IDX_WIDTH: rows computed per pass.
- LEN_WIDTH, 10: width of vector-length field.
- FRAC_BITS, 8: fractional bits; the result is the accumulator arithmetically shifted right by FRAC_BITS (floor).
- ACC_WIDTH, 2*DATA_WIDTH+LEN_WIDTH: accumulator width; accumulation never overflows.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin pass; honoured only in IDLE.
- len  in  LEN_WIDTH  vector length, sampled when start is accepted.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  high only in LOAD.
- in_vec  in  DATA_WIDTH  x[k].
- in_mat  in  DATA_WIDTH*NUM_NODES  M[i][k] for row i in bits [i*DATA_WIDTH +: DATA_WIDTH].
- res_valid  out  1  result beat valid.
- res_ready  in  1  result beat accepted.
- res_data  out  DATA_WIDTH  y[res_idx].
- res_idx  out  IDX_WIDTH  row index of res_data.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse after the last result is accepted.

## Operation
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE: on start, latch len, clear all accumulators and valid tags, then enter LOAD. If len == 0, enter DRAIN instead. start while busy is ignored.
- LOAD: a beat is accepted when in_valid is high. Each accepted beat counts as one advance. After len beats, go to FLUSH.
- Advance: x enters node 0 with valid tag 1. The x and tag shift one node per advance. Row i is delayed i advances by an internal skew lane, so row i meets x[k] at node i.
- A node accumulates a_reg*b_reg (full 2*DATA_WIDTH product, sign-extended to ACC_WIDTH) only when its tag is set.
- No advance occurs in cycles where in_valid is low during LOAD; the chain and skew lanes hold.
- FLUSH: exactly NUM_NODES cycles of advances with tag 0 and zero data. Every accumulator is final on entry to DRAIN.
- DRAIN: row counter r starts at 0, with res_valid=1, res_idx=r, res_data=sat(acc[r]>>>FRAC_BITS).
- r increments on res_valid&res_ready. res_data and res_idx hold while res_ready is low.
- After row NUM_NODES-1 is accepted: done=1 for one cycle, then IDLE.

## Timing
- Reset values: in_ready=0, res_valid=0, res_data=0, res_idx=0, busy=0, done=0. State is IDLE; accumulators, skew lanes and tags are all 0.
- Latency with no stalls: start accepted at cycle 0 gives LOAD in cycles 1..len, FLUSH in cycles len+1..len+NUM_NODES, and first res_valid at cycle len+NUM_NODES+1.
- With continuous res_ready, done pulses at cycle len+2*NUM_NODES+1.
- All outputs are registered; there is no combinational path from in_valid, start or res_ready to any output.
- Reset mid-pass: the block returns to IDLE immediately, and partial sums are discarded.

## Configuration
- MV_MESH_SAT_EN defined: the shifted accumulator is clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- MV_MESH_SAT_EN undefined: the low DATA_WIDTH bits of the shifted accumulator are output (two's-complement wrap).

## Test plan
All scenarios use DATA_WIDTH=16, IDX_WIDTH=2, FRAC_BITS=8.
- Identity: M=I scaled by 0x0100, x=[0x0100,0x0200,0x0300,0x0400], len=4, res_ready=1 -> res_data 0x0100,0x0200,0x0300,0x0400 at idx 0..3. First res_valid at cycle 9, done at cycle 13.
- Overflow: all M and x = 0x7FFF, len=4 -> every row is 0x7FFF with MV_MESH_SAT_EN, and 0xFC00 without it.
- Input stalls: identity case with in_valid deasserted every other cycle -> identical results, and first res_valid is delayed by the number of stall cycles.
- Backpressure: res_ready held low for 5 cycles at r=1 -> res_idx=1 with stable data for 5 cycles, no loss, and done fires once.
- Edge cases:
  - len=0 -> four zero results and done.
  - start pulsed during LOAD -> ignored.
- Reset mid-LOAD: assert rst after 2 beats, then run the identity case -> correct results with no residue from the aborted pass.
